// File: rtl/mem_arbiter.sv
// Byte-serial memory port arbiter: IF word fetches and LSU byte/half/word
// loads and stores share one registered byte bus, LSU has priority.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int IO_BIT_HI = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic              ls_signed,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic [7:0]        mem_din
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state;
  logic              own_ls;
  logic [ADDR_W-1:0] base;
  logic [2:0]        n;
  logic              we;
  logic [31:0]       wdata;
  logic              sgn;
  logic [2:0]        cyc;
  logic              paused;
  logic [31:0]       rbuf;

  logic [1:0]        slot;
  logic [31:0]       assembled;
  logic [31:0]       load_val;
  logic              last_issue;
  logic              finish;
  logic              capture;
  logic              io_addr;
  logic              accept;
  logic [ADDR_W-1:0] nx_base;
  logic [2:0]        nx_n;
  logic              nx_we;
  logic [31:0]       nx_wdata;

  function automatic logic [2:0] size_to_n(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

  // Byte issued at edge k arrives on mem_din in time for edge k+2.
  assign slot       = 2'(cyc - 3'd2);
  assign capture    = !we && (cyc >= 3'd2);
  assign last_issue = (cyc == n - 3'd1);
  assign finish     = we ? (cyc == n) : (cyc == n + 3'd1);
  assign io_addr    = (mem_a[IO_BIT_HI -: 2] == 2'b11);

  assign accept   = rdy_in && (ls_req || (if_req && !if_flush));
  assign nx_base  = ls_req ? ls_addr : if_addr;
  assign nx_n     = ls_req ? size_to_n(ls_size) : 3'd4;
  assign nx_we    = ls_req && ls_we;
  assign nx_wdata = ls_req ? ls_wdata : 32'd0;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path holds an old value (no latch).
    assembled = rbuf;
    case (slot)
      2'd0:    assembled[7:0]   = mem_din;
      2'd1:    assembled[15:8]  = mem_din;
      2'd2:    assembled[23:16] = mem_din;
      default: assembled[31:24] = mem_din;
    endcase
    case (n)
      3'd1:    load_val = {{24{sgn & assembled[7]}}, assembled[7:0]};
      3'd2:    load_val = {{16{sgn & assembled[15]}}, assembled[15:0]};
      default: load_val = assembled;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      own_ls   <= 1'b0;
      base     <= '0;
      n        <= 3'd0;
      we       <= 1'b0;
      wdata    <= 32'd0;
      sgn      <= 1'b0;
      cyc      <= 3'd0;
      paused   <= 1'b0;
      rbuf     <= 32'd0;
      mem_a    <= '0;
      mem_dout <= 8'd0;
      mem_wr   <= 1'b0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= 32'd0;
      ls_rdata <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if_done <= 1'b0;
      ls_done <= 1'b0;
      if (state != IDLE && !own_ls && if_flush) begin
        state  <= IDLE;
        cyc    <= 3'd0;
        paused <= 1'b0;
        mem_wr <= 1'b0;
      end else if (state == IDLE) begin
        mem_wr <= 1'b0;
        if (accept) begin
          own_ls   <= ls_req;
          base     <= nx_base;
          n        <= nx_n;
          we       <= nx_we;
          wdata    <= nx_wdata;
          sgn      <= ls_signed;
          mem_a    <= nx_base;
          mem_dout <= nx_wdata[7:0];
          mem_wr   <= nx_we;
          cyc      <= 3'd1;
          state    <= (nx_n == 3'd1) ? DRAIN : ISSUE;
        end
      end else if (!rdy_in) begin
        paused <= 1'b1;
        mem_wr <= 1'b0;
      end else if (paused) begin
        // Bus was lent out: replay the whole transaction from byte 0.
        paused   <= 1'b0;
        mem_a    <= base;
        mem_dout <= wdata[7:0];
        mem_wr   <= we;
        cyc      <= 3'd1;
        state    <= (n == 3'd1) ? DRAIN : ISSUE;
      end else begin
        if (capture) rbuf <= assembled;
        if (state == ISSUE) begin
          mem_a    <= base + ADDR_W'(cyc);
          mem_dout <= byte_sel(wdata, cyc[1:0]);
          mem_wr   <= we;
          cyc      <= cyc + 3'd1;
          if (last_issue) state <= DRAIN;
        end else begin
          mem_wr <= 1'b0;
          if (finish) begin
            state <= IDLE;
            cyc   <= 3'd0;
            if (own_ls) begin
              ls_done <= 1'b1;
              if (!we) ls_rdata <= load_val;
            end else begin
              if_done <= 1'b1;
              if_data <= assembled;
            end
            // Park the bus off an IO register so an idle port cannot re-read it.
            if (!we && io_addr) mem_a <= '0;
          end else begin
            cyc <= cyc + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions compared against a byte-array memory model.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_flush = 1'b0;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [1:0]  ls_size = 2'd0;
  logic        ls_signed = 1'b0;
  logic [31:0] ls_addr = 32'd0;
  logic [31:0] ls_wdata = 32'd0;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din = 8'd0;

  mem_arbiter #(.ADDR_W(32), .IO_BIT_HI(17)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_signed(ls_signed),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Bus-side RAM (64 KiB, addresses folded) and the reference image.
  logic [7:0] bus_ram [0:65535];
  logic [7:0] ref_ram [0:65535];

  function automatic logic [7:0] fill(input int i);
    logic [15:0] a = 16'(i);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge clk_in) begin
    mem_din <= rdy_in ? bus_ram[mem_a[15:0]] : 8'($urandom);
    if (mem_wr) bus_ram[mem_a[15:0]] <= mem_dout;
  end

  function automatic logic [31:0] exp_load(input logic [31:0] a, input int n, input bit sgn);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_ram[16'(a + 32'(i))]) << (8 * i));
    if (sgn && n < 4 && v[8 * n - 1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  logic [31:0] trace [$];
  logic [39:0] wlog [$];

  // One complete transaction from an idle bus; optional rdy_in pause after edge pause_at.
  task automatic txn(input bit is_ls, input bit we, input logic [1:0] size, input bit sgn,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int pause_at, input int pause_len, input string tag);
    int n, lat;
    bit done, stray;
    logic [31:0] held, got;
    n = !is_ls ? 4 : (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (is_ls) begin
      ls_req = 1'b1; ls_we = we; ls_size = size; ls_signed = sgn;
      ls_addr = addr; ls_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    trace.delete(); wlog.delete();
    lat = 0; done = 1'b0; stray = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk_in); @(negedge clk_in);
      lat++;
      trace.push_back(mem_a);
      if (mem_wr) wlog.push_back({mem_a, mem_dout});
      done = is_ls ? ls_done : if_done;
      if (is_ls ? if_done : ls_done) stray = 1'b1;
      if (!done && c == pause_at) begin
        held = mem_a;
        rdy_in = 1'b0;
        for (int p = 0; p < pause_len; p++) begin
          @(posedge clk_in); @(negedge clk_in);
          check({tag, " pause mem_a"}, mem_a, held);
          check({tag, " pause wr/done"}, {29'd0, mem_wr, if_done, ls_done}, 32'd0);
        end
        rdy_in = 1'b1;
        lat = 0;
        trace.delete(); wlog.delete();
      end
    end
    if (is_ls) ls_req = 1'b0; else if_req = 1'b0;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(we ? n + 1 : n + 2));
    for (int i = 0; i < n && i < trace.size(); i++)
      check({tag, " addr"}, trace[i], addr + 32'(i));
    check({tag, " writes"}, 32'(wlog.size()), 32'(we ? n : 0));
    if (we) begin
      for (int i = 0; i < wlog.size() && i < n; i++) begin
        check({tag, " wr addr"}, wlog[i][39:8], addr + 32'(i));
        check({tag, " wr byte"}, 32'(wlog[i][7:0]), 32'(wdata[8 * i +: 8]));
      end
      for (int i = 0; i < n; i++) ref_ram[16'(addr + 32'(i))] = wdata[8 * i +: 8];
    end else begin
      got = is_ls ? ls_rdata : if_data;
      check({tag, " data"}, got, exp_load(addr, n, is_ls && sgn));
    end
    check({tag, " other done"}, 32'(stray), 32'd0);
    @(posedge clk_in); @(negedge clk_in);
    check({tag, " one-cycle pulse"}, {30'd0, if_done, ls_done}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int ls_at, if_at, pause_at, n_r;
  logic [31:0] a4, ls_rd, if_rd, prev_a, r_addr;
  bit seen_wr, seen_done, r_ls, r_we, r_sgn;
  logic [1:0] r_size;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      bus_ram[i] <= fill(i);
      ref_ram[i] = fill(i);
    end
    bus_ram[16'h100] <= 8'h13; bus_ram[16'h101] <= 8'h05;
    bus_ram[16'h102] <= 8'hA0; bus_ram[16'h103] <= 8'h00;
    bus_ram[16'h200] <= 8'h80;
    ref_ram[16'h100] = 8'h13; ref_ram[16'h101] = 8'h05;
    ref_ram[16'h102] = 8'hA0; ref_ram[16'h103] = 8'h00;
    ref_ram[16'h200] = 8'h80;

    #2 rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("reset mem_a", mem_a, 32'd0);
    check("reset mem_dout/wr", {23'd0, mem_dout, mem_wr}, 32'd0);
    check("reset dones", {30'd0, if_done, ls_done}, 32'd0);
    check("reset if_data", if_data, 32'd0);
    check("reset ls_rdata", ls_rdata, 32'd0);
    rst_in = 1'b1;
    rdy_in = 1'b1;
    @(negedge clk_in);

    txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 0, 0, "fetch 0x100");
    check("fetch word value", if_data, 32'h00A00513);

    txn(1'b1, 1'b0, 2'd0, 1'b1, 32'h200, 32'd0, 0, 0, "lb signed");
    check("lb signed value", ls_rdata, 32'hFFFFFF80);
    txn(1'b1, 1'b0, 2'd0, 1'b0, 32'h200, 32'd0, 0, 0, "lbu");
    check("lbu value", ls_rdata, 32'h00000080);

    txn(1'b1, 1'b1, 2'd1, 1'b0, 32'h301, 32'h0000BEEF, 0, 0, "sh 0x301");
    txn(1'b1, 1'b0, 2'd1, 1'b0, 32'h301, 32'd0, 0, 0, "lhu 0x301");
    check("lhu value", ls_rdata, 32'h0000BEEF);

    // Simultaneous requests: LSU first, IF accepted on the edge after ls_done.
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_signed = 1'b0; ls_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h100;
    ls_at = 0; if_at = 0; a4 = 32'd0; ls_rd = 32'd0; if_rd = 32'd0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk_in); @(negedge clk_in);
      if (c == 4) a4 = mem_a;
      if (ls_done && ls_at == 0) begin ls_at = c; ls_req = 1'b0; ls_rd = ls_rdata; end
      if (if_done && if_at == 0) begin if_at = c; if_req = 1'b0; if_rd = if_data; end
      if (ls_at != 0 && if_at != 0) break;
    end
    ls_req = 1'b0; if_req = 1'b0;
    check("arb ls first", 32'(ls_at), 32'd3);
    check("arb if start addr", a4, 32'h100);
    check("arb if done", 32'(if_at), 32'd9);
    check("arb ls data", ls_rd, 32'h80);
    check("arb if data", if_rd, 32'h00A00513);
    @(negedge clk_in);

    // LSU request arriving mid-fetch waits for the fetch.
    if_req = 1'b1; if_addr = 32'h100;
    ls_at = 0; if_at = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk_in); @(negedge clk_in);
      if (ls_done && ls_at == 0) begin ls_at = c; ls_req = 1'b0; ls_rd = ls_rdata; end
      if (if_done && if_at == 0) begin if_at = c; if_req = 1'b0; if_rd = if_data; end
      if (c == 2) begin
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_signed = 1'b1; ls_addr = 32'h200;
      end
      if (ls_at != 0 && if_at != 0) break;
    end
    ls_req = 1'b0; if_req = 1'b0;
    check("nopreempt if done", 32'(if_at), 32'd6);
    check("nopreempt ls done", 32'(ls_at), 32'd9);
    check("nopreempt ls data", ls_rd, 32'hFFFFFF80);
    check("nopreempt if data", if_rd, 32'h00A00513);
    @(negedge clk_in);

    // Flush two cycles into a fetch.
    if_req = 1'b1; if_addr = 32'h100;
    seen_wr = 1'b0; seen_done = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk_in); @(negedge clk_in);
      seen_wr = seen_wr | mem_wr;
      seen_done = seen_done | if_done | ls_done;
      if (c == 2) begin if_flush = 1'b1; if_req = 1'b0; end
      if (c == 3) if_flush = 1'b0;
    end
    check("flush no done", 32'(seen_done), 32'd0);
    check("flush no write", 32'(seen_wr), 32'd0);
    txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h400, 32'd0, 0, 0, "fetch after flush");

    // Flush in IDLE suppresses IF acceptance that cycle.
    prev_a = mem_a;
    if_req = 1'b1; if_addr = 32'h600; if_flush = 1'b1;
    @(posedge clk_in); @(negedge clk_in);
    check("idle flush blocks accept", mem_a, prev_a);
    if_req = 1'b0; if_flush = 1'b0;
    @(negedge clk_in);

    txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 2, 5, "paused fetch");
    check("paused fetch value", if_data, 32'h00A00513);

    // Asynchronous reset in the middle of a word store.
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h500; ls_wdata = 32'h11223344;
    @(posedge clk_in); @(negedge clk_in);
    @(posedge clk_in); @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    check("async rst mem_a", mem_a, 32'd0);
    check("async rst mem_dout/wr", {23'd0, mem_dout, mem_wr}, 32'd0);
    check("async rst if_data", if_data, 32'd0);
    check("async rst ls_rdata", ls_rdata, 32'd0);
    ls_req = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk_in); @(negedge clk_in);
      seen_done = seen_done | ls_done | if_done;
    end
    check("rst no done", 32'(seen_done), 32'd0);

    for (int k = 0; k < 200; k++) begin
      r_ls   = ($urandom_range(3) != 0);
      r_we   = r_ls && ($urandom_range(1) == 1);
      r_size = 2'($urandom_range(3));
      r_sgn  = ($urandom_range(1) == 1);
      case ($urandom_range(2))
        0:       r_addr = 32'h1000 + 32'($urandom_range(15));
        1:       r_addr = 32'hFFFF_FFFC + 32'($urandom_range(3));
        default: r_addr = 32'h2000 + 32'($urandom_range(7));
      endcase
      pause_at = ($urandom_range(4) == 0) ? $urandom_range(1, 3) : 0;
      n_r = $urandom_range(1, 4);
      txn(r_ls, r_we, r_size, r_sgn, r_addr, $urandom, pause_at, n_r, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the CPU's single byte-wide memory port (mem_a/mem_dout/mem_din/mem_wr) between two requesters:
  - instruction fetch (IF): 4-byte reads;
  - load/store unit (LSU): 1/2/4-byte reads and writes.
- Converts each word or halfword request into byte-serial bus cycles against the synchronous RAM/IO map.
- Reassembles read data little-endian and returns it with a one-cycle done pulse.
- Sits inside cpu, between the core pipeline and the top-level memory mux; honours rdy_in pauses.

Parameters:
- ADDR_W, 32, width of byte addresses.
- IO_BIT_HI, 17, upper bit of the IO decode field; IO space is a[IO_BIT_HI:IO_BIT_HI-1]==2'b11.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  bus available; low = HCI owns the memory bus.
- if_req  input  1  fetch request, held until if_done or flush.
- if_addr  input  ADDR_W  fetch address.
- if_flush  input  1  abort any fetch in progress (branch/jump).
- if_done  output  1  one-cycle pulse, if_data valid.
- if_data  output  32  fetched instruction word.
- ls_req  input  1  LSU request, held until ls_done.
- ls_we  input  1  1 = store, 0 = load.
- ls_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word.
- ls_signed  input  1  sign-extend loads.
- ls_addr  input  ADDR_W  access address.
- ls_wdata  input  32  store data; low bytes used.
- ls_done  output  1  one-cycle pulse.
- ls_rdata  output  32  extended load data.
- mem_a  output  ADDR_W  byte address to the bus.
- mem_dout  output  8  write byte.
- mem_wr  output  1  1 = write cycle.
- mem_din  input  8  read byte; valid one cycle after mem_a is registered at the RAM.

Behaviour:
- Reset (rst_in low, async):
  - state=IDLE; all counters 0.
  - mem_a=0, mem_dout=0, mem_wr=0.
  - if_done=0, ls_done=0, if_data=0, ls_rdata=0.
- All bus outputs are registered.
- States: IDLE, ISSUE, DRAIN.
- IDLE, on an edge with rdy_in=1:
  - ls_req has priority; otherwise if_req (only if if_flush=0).
  - Latch owner, address, size N (1/2/4; IF always 4), we, and wdata.
  - Register byte 0 onto mem_a/mem_dout/mem_wr. Go to ISSUE with issue count=1.
- ISSUE:
  - Each edge registers byte i: mem_a=base+i, mem_dout=wdata[8i+7:8i], mem_wr=we.
  - Reads capture mem_din into byte slot i-2 (two-edge pipeline from address register to capture).
  - After the last byte is issued, go to DRAIN.
- DRAIN:
  - mem_wr is forced 0; mem_a holds its last value.
  - Reads complete capture of the remaining bytes; writes spend one cycle letting the final byte commit.
  - Then pulse the owner's done for exactly one cycle and return to IDLE.
- Latency, counted from the accept edge E0:
  - Read of N bytes: done high in the cycle after edge E0+N+1. Word read = 6 cycles total including the accept cycle.
  - Write of N bytes: done high in the cycle after edge E0+N.
- No preemption: an in-progress IF transaction completes even if ls_req rises. Back-to-back accepts are allowed on the edge after done.
- Address arithmetic: base+i wraps modulo 2^ADDR_W. Misaligned accesses are legal and issued byte-serial.
- Load extension: ls_rdata is sign- or zero-extended from bit 8N-1 according to ls_signed; stores ignore ls_signed.
- if_data and ls_rdata hold their value until the next done of the same owner.
- if_flush:
  - While the owner is IF, returns to IDLE on the next edge with no if_done and mem_wr=0.
  - While the owner is LSU, or in IDLE, it suppresses IF acceptance that cycle only.
- rdy_in low:
  - Freezes all state, and mem_wr is forced 0.
  - When rdy_in returns high, the current transaction restarts from byte 0 (partial read data discarded).
  - An IO-space store may therefore repeat; this is accepted behaviour.
- IO reads (mem_a in IO space): each byte is issued exactly once per non-restarted transaction; no speculative reissue.
- Simultaneous if_req and ls_req in IDLE: LSU is granted; IF waits.

Test Plan:
- Word fetch: RAM[0x100..0x103]=13,05,A0,00 (hex), if_req addr=0x100 → mem_a steps 0x100..0x103 on consecutive cycles; if_done pulses once 6 cycles after accept with if_data=0x00A00513.
- Signed byte load: RAM[0x200]=0x80, ls_size=0, ls_signed=1 → ls_rdata=0xFFFFFF80. The same access with ls_signed=0 → 0x00000080.
- Half store then load: store 0xBEEF at 0x301, ls_size=1 → mem_wr high on exactly 2 cycles at 0x301/0x302 with bytes EF/BE; ls_done after 3 cycles. A subsequent half load returns 0x0000BEEF.
- Arbitration: if_req and ls_req raised on the same cycle → LSU served first; the IF transaction starts on the edge after ls_done. Raising ls_req during an IF transaction → the IF completes first.
- Flush: assert if_flush two cycles into a fetch → no if_done, mem_wr=0 throughout, state returns to IDLE. A new if_req at 0x400 then completes normally.
- Pause/reset: drop rdy_in mid-word-read for 5 cycles → outputs frozen, read restarts at byte 0, correct data returned. Pulse rst_in low mid-store → all outputs return to 0 immediately (asynchronously) and no done pulse occurs.
